// File: rtl/pw_lockout_checker.sv
// Front-panel password checker with consecutive-failure lockout and idle auto-relock.
// Latency: a key rise in cycle n updates state, status outputs and pulses valid in cycle n+1.
// Backpressure: none; presses during lockout are dropped, and a held key yields a single event.
module pw_lockout_checker #(
  parameter int DIGIT_W        = 4,
  parameter int N_DIGITS       = 4,
  parameter int N_ACCOUNTS     = 16,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000,
  parameter int UNLOCK_CYCLES  = 0,
  localparam int PW_W = DIGIT_W * N_DIGITS,
  localparam int AW   = $clog2(N_ACCOUNTS + 1),
  localparam int FW   = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1,
  localparam int LW   = $clog2(LOCKOUT_CYCLES + 1),
  localparam int BW   = $clog2(PW_W + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key,
  input  logic [PW_W-1:0]            s,
  input  logic [N_ACCOUNTS*PW_W-1:0] pw_table,
  output logic                       unlocked,
  output logic                       locked_out,
  output logic [AW-1:0]              account,
  output logic [FW-1:0]              fail_count,
  output logic [LW-1:0]              lockout_left,
  output logic [BW-1:0]              bits_active,
  output logic                       attempt_pulse,
  output logic                       match_pulse
);

  // Idle counter only needs to reach UNLOCK_CYCLES-1; keep at least one bit when disabled.
  localparam int IW = (UNLOCK_CYCLES > 0) ? $clog2(UNLOCK_CYCLES + 1) : 1;
  localparam logic [AW-1:0] NO_ACCOUNT = AW'(N_ACCOUNTS);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            key_q;
  logic            rise;
  logic            hit;
  logic [AW-1:0]   hit_idx;
  logic [AW-1:0]   account_nxt;
  logic [FW-1:0]   fail_nxt;
  logic [LW-1:0]   left_nxt;
  logic [IW-1:0]   idle_cnt, idle_nxt;
  logic            attempt_nxt, match_nxt;

  assign rise = key & ~key_q;

  // Priority match: scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ACCOUNTS - 1; i >= 0; i--) begin
      if (pw_table[i*PW_W +: PW_W] == s) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end

  // Live popcount of the switch bank for the status display.
  always_comb begin
    bits_active = '0;
    for (int i = 0; i < PW_W; i++) begin
      bits_active = bits_active + BW'(s[i]);
    end
  end

  // Next-state and next-output logic for the session FSM.
  always_comb begin
    state_nxt   = state;
    account_nxt = account;
    fail_nxt    = fail_count;
    left_nxt    = lockout_left;
    idle_nxt    = idle_cnt;
    attempt_nxt = 1'b0;
    match_nxt   = 1'b0;
    case (state)
      ST_LOCKED: begin
        if (rise) begin
          attempt_nxt = 1'b1;
          if (hit) begin
            state_nxt   = ST_UNLOCKED;
            account_nxt = hit_idx;
            fail_nxt    = '0;
            idle_nxt    = '0;
            match_nxt   = 1'b1;
          end else if (int'(fail_count) + 1 >= MAX_FAILS) begin
            state_nxt = ST_LOCKOUT;
            left_nxt  = LW'(LOCKOUT_CYCLES);
            fail_nxt  = '0;
          end else begin
            fail_nxt = fail_count + FW'(1);
          end
        end
      end
      ST_UNLOCKED: begin
        if (rise) begin
          // Logout: not an attempt, so no pulses.
          state_nxt   = ST_LOCKED;
          account_nxt = NO_ACCOUNT;
          idle_nxt    = '0;
        end else if (UNLOCK_CYCLES != 0) begin
          // Relocking on the edge where the count would reach UNLOCK_CYCLES keeps
          // the session open for exactly UNLOCK_CYCLES cycles.
          if (int'(idle_cnt) >= UNLOCK_CYCLES - 1) begin
            state_nxt   = ST_LOCKED;
            account_nxt = NO_ACCOUNT;
            idle_nxt    = '0;
          end else begin
            idle_nxt = idle_cnt + IW'(1);
          end
        end
      end
      ST_LOCKOUT: begin
        if (lockout_left <= LW'(1)) begin
          state_nxt = ST_LOCKED;
          left_nxt  = '0;
        end else begin
          left_nxt = lockout_left - LW'(1);
        end
      end
      default: begin
        state_nxt   = ST_LOCKED;
        account_nxt = NO_ACCOUNT;
        fail_nxt    = '0;
        left_nxt    = '0;
        idle_nxt    = '0;
      end
    endcase
  end

  // State and registered outputs; reset forces key_q high so a held key needs a fresh press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_LOCKED;
      key_q         <= 1'b1;
      account       <= NO_ACCOUNT;
      fail_count    <= '0;
      lockout_left  <= '0;
      idle_cnt      <= '0;
      attempt_pulse <= 1'b0;
      match_pulse   <= 1'b0;
      unlocked      <= 1'b0;
      locked_out    <= 1'b0;
    end else begin
      state         <= state_nxt;
      key_q         <= key;
      account       <= account_nxt;
      fail_count    <= fail_nxt;
      lockout_left  <= left_nxt;
      idle_cnt      <= idle_nxt;
      attempt_pulse <= attempt_nxt;
      match_pulse   <= match_nxt;
      unlocked      <= (state_nxt == ST_UNLOCKED);
      locked_out    <= (state_nxt == ST_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_pw_lockout_checker.sv
// Bench for pw_lockout_checker: directed test-plan sequence plus randomized presses.
// Expected status events are queued by a transaction-level model; a monitor pops on each DUT event.
// The DUT has no backpressure; the bench only keeps key low at least one cycle between presses.
module tb_pw_lockout_checker;

  localparam int LOCK = 8;
  localparam int UNL  = 20;
  localparam int NACC = 16;
  localparam int MAXF = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              key;
  logic [15:0]       s;
  logic [NACC*16-1:0] pw_table;
  logic              unlocked, locked_out;
  logic [4:0]        account;
  logic [1:0]        fail_count;
  logic [3:0]        lockout_left;
  logic [4:0]        bits_active;
  logic              attempt_pulse, match_pulse;

  pw_lockout_checker #(
    .LOCKOUT_CYCLES(LOCK),
    .UNLOCK_CYCLES (UNL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key          (key),
    .s            (s),
    .pw_table     (pw_table),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .account      (account),
    .fail_count   (fail_count),
    .lockout_left (lockout_left),
    .bits_active  (bits_active),
    .attempt_pulse(attempt_pulse),
    .match_pulse  (match_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int cyc;
    bit attempt;
    bit match;
    bit unl;
    bit lo;
    int acct;
    int fc;
    int left;
  } ev_t;

  ev_t exp_q[$];
  logic [15:0] tbl [NACC];
  int m_mode  = 0;   // 0 locked, 1 session open, 2 locked out
  int m_fails = 0;
  int m_end   = 0;   // first cycle the pending timed exit is visible

  task automatic push(input int c, input bit a, input bit m, input bit u, input bit l,
                      input int ac, input int f, input int lf);
    ev_t e;
    e.cyc = c; e.attempt = a; e.match = m; e.unl = u; e.lo = l;
    e.acct = ac; e.fc = f; e.left = lf;
    exp_q.push_back(e);
  endtask

  // Emit timed exits (lockout expiry, idle relock) that fall due by cycle 'now'.
  task automatic flush(input int now);
    if (m_mode != 0 && now >= m_end) begin
      push(m_end, 0, 0, 0, 0, NACC, 0, 0);
      m_mode = 0;
    end
  endtask

  // A key rise seen in cycle c; results appear in cycle c+1.
  task automatic model_press(input int c, input logic [15:0] val);
    int idx;
    idx = -1;
    for (int i = 0; i < NACC; i++)
      if (idx < 0 && tbl[i] == val) idx = i;
    case (m_mode)
      0: begin
        if (idx >= 0) begin
          push(c + 1, 1, 1, 1, 0, idx, 0, 0);
          m_mode = 1; m_end = c + 1 + UNL; m_fails = 0;
        end else if (m_fails + 1 >= MAXF) begin
          push(c + 1, 1, 0, 0, 1, NACC, 0, LOCK);
          m_mode = 2; m_end = c + 1 + LOCK; m_fails = 0;
        end else begin
          m_fails++;
          push(c + 1, 1, 0, 0, 0, NACC, m_fails, 0);
        end
      end
      1: begin
        push(c + 1, 0, 0, 0, 0, NACC, 0, 0);
        m_mode = 0;
      end
      default: ;
    endcase
  endtask

  task automatic model_reset(input int r);
    push(r + 1, 0, 0, 0, 0, NACC, 0, 0);
    m_mode = 0; m_fails = 0;
  endtask

  // ---------------- monitor ----------------
  bit   mon_en = 0;
  bit   p_unl, p_lo;
  int   p_acct, p_fc, p_left;

  always @(negedge clk) begin
    if (mon_en) begin
      if (attempt_pulse || unlocked != p_unl || locked_out != p_lo) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_attempt", attempt_pulse, e.attempt);
          chk("ev_match", match_pulse, e.match);
          chk("ev_unlocked", unlocked, e.unl);
          chk("ev_locked_out", locked_out, e.lo);
          chk("ev_account", account, e.acct);
          chk("ev_fail_count", fail_count, e.fc);
          chk("ev_lockout_left", lockout_left, e.left);
        end
      end else begin
        chk("quiet_match", match_pulse, 0);
        chk("quiet_account", account, p_acct);
        chk("quiet_fail_count", fail_count, p_fc);
      end
      if (locked_out && p_lo) chk("lockout_dec", lockout_left, p_left - 1);
      if (!locked_out) chk("left_idle_zero", lockout_left, 0);
      p_unl = unlocked; p_lo = locked_out;
      p_acct = account; p_fc = fail_count; p_left = lockout_left;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    flush(cyc);
  endtask

  task automatic press(input logic [15:0] val, input int hold, input int gap);
    s   = val;
    key = 1'b1;
    model_press(cyc, val);
    repeat (hold) step();
    key = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NACC; i++) tbl[i] = 16'($urandom);
    tbl[0]  = 16'hEF93;
    tbl[3]  = 16'hC9C9;
    tbl[14] = 16'hC9C9;
    tbl[15] = 16'h0001;
    for (int i = 1; i < NACC; i++)
      if (i != 3 && i != 14 && i != 15 && (tbl[i] == 16'hEF93 || tbl[i] == 16'h1234))
        tbl[i] = 16'h5A5A;
    for (int i = 0; i < NACC; i++) pw_table[i*16 +: 16] = tbl[i];

    // Reset with key held high.
    reset = 1'b0;
    key   = 1'b1;
    s     = 16'hEF93;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_locked_out", locked_out, 0);
    chk("rst_account", account, NACC);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_lockout_left", lockout_left, 0);
    chk("rst_attempt", attempt_pulse, 0);
    chk("rst_match", match_pulse, 0);
    p_unl = 0; p_lo = 0; p_acct = NACC; p_fc = 0; p_left = 0;
    mon_en = 1;
    repeat (4) step();          // key still held: no event allowed
    key = 1'b0;
    repeat (2) step();

    // Directed sequence.
    press(16'hEF93, 3, 4);      // unlock account 0
    press(16'h1111, 1, 3);      // logout
    press(16'hC9C9, 1, 3);      // account 3, not 14
    press(16'h0000, 1, 3);      // logout
    press(16'h1234, 1, 2);
    press(16'h1234, 1, 2);
    press(16'h1234, 1, 1);      // lockout
    press(16'h1234, 1, 2);      // ignored
    press(16'hEF93, 1, 10);     // ignored
    press(16'h1234, 1, 2);
    press(16'h1234, 1, 2);
    press(16'h0001, 1, 1);      // account 15, fail_count back to 0
    repeat (25) step();         // idle relock
    press(16'h1234, 1, 2);
    press(16'h1234, 1, 2);
    press(16'h1234, 1, 0);      // lockout entered
    repeat (3) step();
    chk("left_before_reset", lockout_left, 5);
    reset = 1'b0;
    model_reset(cyc);
    step();
    reset = 1'b1;
    step();
    press(16'hEF93, 1, 3);
    press(16'h0000, 1, 3);

    // Switch popcount, no clock involved.
    s = 16'hFFFF;
    #1;
    chk("bits_all_ones", bits_active, 16);
    s = 16'h0000;
    #1;
    chk("bits_zero", bits_active, 0);
    step();

    // Randomized presses; s wanders between rises to show it is only sampled on rise.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] v;
      int gap;
      v = ($urandom_range(1) == 1) ? tbl[$urandom_range(NACC - 1)] : 16'($urandom);
      gap = $urandom_range(25, 1);
      s = v;
      #1;
      chk("bits_random", bits_active, $countones(v));
      press(v, $urandom_range(4, 1), 0);
      for (int g = 0; g < gap; g++) begin
        step();
        s = 16'($urandom);
      end
    end

    key = 1'b0;
    repeat (40) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pw_lockout_checker.md
# pw_lockout_checker

Parametrised, clocked successor to the front-panel password checker. It accepts an N-digit hex entry from the switch bank on each rising edge of the `key` pushbutton and matches it against a table of account passwords supplied by the parent. It tracks consecutive failures, enforces a timed lockout after `MAX_FAILS` misses and auto-relocks an idle unlocked session. Its outputs drive the parent's seven-segment and LED status logic.

## Interface
- `DIGIT_W`, 4: bits per digit.
- `N_DIGITS`, 4: digits per password; `PW_W = DIGIT_W*N_DIGITS`.
- `N_ACCOUNTS`, 16: table entries; `AW = $clog2(N_ACCOUNTS+1)`.
- `MAX_FAILS`, 3: consecutive misses that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 50_000_000: lockout length in clocks (≥1).
- `UNLOCK_CYCLES`, 0: idle clocks before auto-relock; 0 disables auto-relock.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-low reset.
- `key` input 1: submit button, already synchronised and debounced, active-high level.
- `s` input PW_W: entry; digit 0 is `s[DIGIT_W-1:0]`.
- `pw_table` input N_ACCOUNTS*PW_W: entry i is `pw_table[i*PW_W +: PW_W]`.
- `unlocked` output 1: session open.
- `locked_out` output 1: lockout active.
- `account` output AW: matched index; `N_ACCOUNTS` is the sentinel for none.
- `fail_count` output $clog2(MAX_FAILS+1): consecutive misses.
- `lockout_left` output $clog2(LOCKOUT_CYCLES+1): remaining lockout clocks.
- `bits_active` output $clog2(PW_W+1): combinational popcount of `s`.
- `attempt_pulse` output 1: one-cycle pulse per evaluated attempt.
- `match_pulse` output 1: one-cycle pulse per successful attempt.

## Operation
- Edge detect: `key_q` registers `key`; `rise = key & ~key_q`. Only `rise` acts. Held `key` gives one event.
- Match: combinational compare of `s` against every entry. Hit index is a priority encode, so the lowest index wins on duplicates.
- FSM states: LOCKED, UNLOCKED, LOCKOUT.
- LOCKED, `rise`, hit at index i: go to UNLOCKED; `account`=i; `fail_count`=0; pulse `attempt_pulse` and `match_pulse`.
- LOCKED, `rise`, miss, `fail_count+1 < MAX_FAILS`: `fail_count`++; stay LOCKED; pulse `attempt_pulse`.
- LOCKED, `rise`, miss, `fail_count+1 == MAX_FAILS`: go to LOCKOUT; `lockout_left`=LOCKOUT_CYCLES; `fail_count`=0; pulse `attempt_pulse`.
- UNLOCKED, `rise` (any `s`): logout to LOCKED; `account`=N_ACCOUNTS; no pulses. Logout is not counted as an attempt.
- UNLOCKED, idle timer: an internal counter clears on entry and on `rise`, and increments otherwise. When `UNLOCK_CYCLES`≠0 and it reaches `UNLOCK_CYCLES`, go to LOCKED with `account`=N_ACCOUNTS.
- LOCKOUT: `rise` is ignored, with no pulses and no counting. `lockout_left` decrements every clock; the clock it goes 1→0, the state becomes LOCKED.
- `unlocked` = (state==UNLOCKED); `locked_out` = (state==LOCKOUT). Both are registered and decoded from state, never both 1.
- `account` equals N_ACCOUNTS whenever state≠UNLOCKED.
- All counters saturate by construction and never wrap.

## Timing
- Reset (`reset`=0 at a `clk` edge) gives: state LOCKED, `unlocked`=0, `locked_out`=0, `account`=N_ACCOUNTS, `fail_count`=0, `lockout_left`=0, pulses 0, idle counter 0, `key_q`=1.
- `key_q`=1 at reset means a key held through reset produces no event until it is released and pressed again.
- Reset overrides everything, including mid-lockout and mid-session. It takes effect at the same edge.
- Latency: `rise` is seen in cycle n. State, outputs and pulses update at the edge ending cycle n and are valid in cycle n+1. Pulses last exactly one cycle.
- Lockout duration: `locked_out` stays high for exactly LOCKOUT_CYCLES cycles. The first cycle with `rise` honoured is the one after it falls.
- Auto-relock: `unlocked` falls exactly UNLOCK_CYCLES cycles after the last `rise` or after entering UNLOCKED.
- `s` is sampled only in the `rise` cycle. Changes to `s` at other times have no effect beyond `bits_active`.

## Test plan
Config: defaults except LOCKOUT_CYCLES=8, UNLOCK_CYCLES=20; entry 0=16'hEF93, entry 3=16'hC9C9, entry 15=16'h0001, entry 14=16'hC9C9 (duplicate of entry 3).
- Reset with `key` held high, then release and press with `s`=16'hEF93 → no event during hold. After the press, `unlocked`=1 and `account`=0 one cycle after `rise`; `match_pulse` is high 1 cycle.
- Press with `s`=16'hC9C9 → `account`=3, not 14. A second press while unlocked → `unlocked`=0, `account`=16, no `attempt_pulse`.
- Three presses with `s`=16'h1234 → `fail_count` goes 1, 2, then `locked_out`=1 with `fail_count`=0. `locked_out` stays high exactly 8 cycles, and `lockout_left` counts 8→0. Presses made during lockout produce no pulses.
- Two misses, then `s`=16'h0001 → `fail_count` goes 2→0, `account`=15. With 20 idle cycles, `unlocked` drops on the 20th cycle and `account`=16.
- Pull `reset` low mid-lockout (`lockout_left`=5) → next cycle: LOCKED, all outputs at reset values. Then a correct password unlocks.
- `s`=18'h0FFFF-equivalent 16'hFFFF → `bits_active`=16; `s`=0 → `bits_active`=0, both with no clock dependence.
